// File: rtl/rd_pkg.sv
// Shared reward defaults and signed saturation helpers
// for the traffic reward accumulator.
package rd_pkg;

    localparam int R_LOW_DEF  = 10;
    localparam int R_MID_DEF  = -1;
    localparam int R_HIGH_DEF = -10;

    typedef logic signed [63:0] wide_t;

    function automatic wide_t sat_clamp(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/rd_lane.sv
// Single-lane level classifier: maps a queue level to
// its low / mid / high reward.
module rd_lane #(
    parameter int L_WIDTH = 4,
    parameter int R_WIDTH = 16
) (
    input  logic [L_WIDTH-1:0]        lvl_i,
    input  logic [L_WIDTH-1:0]        th_low_i,
    input  logic [L_WIDTH-1:0]        th_high_i,
    input  logic signed [R_WIDTH-1:0] r_low_i,
    input  logic signed [R_WIDTH-1:0] r_mid_i,
    input  logic signed [R_WIDTH-1:0] r_high_i,
    output logic signed [R_WIDTH-1:0] rew_o
);

    logic is_low;
    logic is_high;

    // low check wins when the thresholds overlap
    assign is_low  = lvl_i <= th_low_i;
    assign is_high = !is_low && (lvl_i >= th_high_i);

    always_comb begin
        rew_o = r_mid_i;
        unique case (1'b1)
            is_low:  rew_o = r_low_i;
            is_high: rew_o = r_high_i;
            default: rew_o = r_mid_i;
        endcase
    end

endmodule

// File: rtl/rd_acc.sv
// Two-stage lane reward pipeline with saturating
// per-episode accumulation on the output handshake.
module rd_acc
    import rd_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int L_WIDTH = 4,
    parameter int R_WIDTH = 16,
    parameter int A_WIDTH = 24,
    parameter int E_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_LANES*L_WIDTH-1:0]   L_flat,
    input  logic [L_WIDTH-1:0]           th_low,
    input  logic [L_WIDTH-1:0]           th_high,
    input  logic signed [R_WIDTH-1:0]    r_low,
    input  logic signed [R_WIDTH-1:0]    r_mid,
    input  logic signed [R_WIDTH-1:0]    r_high,
    input  logic [E_WIDTH-1:0]           ep_len,
    input  logic                         clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [R_WIDTH-1:0]    R,
    output logic signed [A_WIDTH-1:0]    R_acc,
    output logic                         ep_done,
    output logic                         sat
);

    logic signed [R_WIDTH-1:0] lane_rew [N_LANES];
    logic signed [R_WIDTH-1:0] s1_rew_q [N_LANES];
    logic                      s1_valid_q;
    logic                      ov_q;
    logic signed [R_WIDTH-1:0] R_q;
    logic signed [A_WIDTH-1:0] R_acc_q;
    logic [E_WIDTH-1:0]        cnt_q;
    logic                      ep_done_q;
    logic                      sat_q;

    logic               s2_adv;
    logic               in_fire;
    logic               out_fire;
    wide_t              sum;
    wide_t              r_wide;
    logic               r_clip;
    wide_t              acc_sum;
    wide_t              acc_wide;
    logic               acc_clip;
    logic [E_WIDTH-1:0] ep_lim;
    logic               ep_last;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        rd_lane #(
            .L_WIDTH (L_WIDTH),
            .R_WIDTH (R_WIDTH)
        ) u_lane (
            .lvl_i     (L_flat[i*L_WIDTH +: L_WIDTH]),
            .th_low_i  (th_low),
            .th_high_i (th_high),
            .r_low_i   (r_low),
            .r_mid_i   (r_mid),
            .r_high_i  (r_high),
            .rew_o     (lane_rew[i])
        );
    end

    assign s2_adv   = !ov_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = ov_q && out_ready;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sum = sum + wide_t'(s1_rew_q[i]);
        end
        r_wide = sat_clamp(sum, R_WIDTH);
        r_clip = r_wide != sum;
    end

    // a zero counter marks the first step of a fresh episode
    always_comb begin
        ep_lim   = (ep_len == '0) ? E_WIDTH'(1) : ep_len;
        ep_last  = cnt_q >= (ep_lim - E_WIDTH'(1));
        acc_sum  = ((cnt_q == '0) ? wide_t'(0) : wide_t'(R_acc_q))
                 + wide_t'(R_q);
        acc_wide = sat_clamp(acc_sum, A_WIDTH);
        acc_clip = acc_wide != acc_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_rew_q   <= '{default: '0};
            ov_q       <= 1'b0;
            R_q        <= '0;
            R_acc_q    <= '0;
            cnt_q      <= '0;
            ep_done_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (in_fire) s1_rew_q <= lane_rew;
            if (s2_adv) ov_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) R_q <= r_wide[R_WIDTH-1:0];
            ep_done_q <= out_fire && !clr && ep_last;
            if (clr) begin
                R_acc_q <= '0;
                cnt_q   <= '0;
                sat_q   <= 1'b0;
            end else begin
                if (out_fire) begin
                    R_acc_q <= acc_wide[A_WIDTH-1:0];
                    cnt_q   <= ep_last ? '0 : cnt_q + E_WIDTH'(1);
                end
                if ((s2_adv && s1_valid_q && r_clip) || (out_fire && acc_clip))
                    sat_q <= 1'b1;
            end
        end
    end

    assign out_valid = ov_q;
    assign R         = R_q;
    assign R_acc     = R_acc_q;
    assign ep_done   = ep_done_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_rd_acc.sv
// Bench for rd_acc: vector table, directed corner cases
// and randomized traffic against a queue-based model.
module tb_rd_acc;
    import rd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic               clr, ep_done, sat;
    logic [15:0]        L_flat;
    logic [3:0]         th_low, th_high;
    logic signed [15:0] r_low, r_mid, r_high, R;
    logic [7:0]         ep_len;
    logic signed [23:0] R_acc;

    logic              in_valid8, in_ready8, out_valid8, out_ready8;
    logic              clr8, ep_done8, sat8;
    logic [15:0]       L8;
    logic signed [7:0] r8_low, r8_mid, r8_high, R8, R_acc8;
    logic [7:0]        ep_len8;

    rd_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .L_flat(L_flat), .th_low(th_low), .th_high(th_high),
        .r_low(r_low), .r_mid(r_mid), .r_high(r_high),
        .ep_len(ep_len), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .R(R), .R_acc(R_acc),
        .ep_done(ep_done), .sat(sat)
    );

    rd_acc #(.R_WIDTH(8), .A_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .L_flat(L8), .th_low(th_low), .th_high(th_high),
        .r_low(r8_low), .r_mid(r8_mid), .r_high(r8_high),
        .ep_len(ep_len8), .clr(clr8), .out_valid(out_valid8),
        .out_ready(out_ready8), .R(R8), .R_acc(R_acc8),
        .ep_done(ep_done8), .sat(sat8)
    );

    typedef struct {
        int r;
        bit clip;
    } exp_t;

    typedef struct {
        logic [3:0]  tl;
        logic [3:0]  th;
        logic [15:0] lv;
        int          r;
    } vec_t;

    exp_t   sbq[$];
    int     n_chk = 0;
    int     n_err = 0;
    longint m_acc;
    int     m_cnt;
    bit     m_sat, m_done, prev_stall, prev_clr, acc_fire;
    longint prev_R;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w);
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic int lane_val(input int l);
        if (l <= int'(th_low)) return int'(r_low);
        if (l >= int'(th_high)) return int'(r_high);
        return int'(r_mid);
    endfunction

    function automatic longint raw_sum();
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s += lane_val(int'(L_flat[i*4 +: 4]));
        return s;
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 0;
        m_done = 0;
        prev_stall = 0;
        prev_clr = 0;
        prev_R = 0;
    endtask

    // one clock: sample before the edge, update model, check after the edge
    task automatic step();
        bit     ov;
        exp_t   e;
        longint rout, v, raw;
        int     lim;
        #1;
        ov = out_valid;
        rout = R;
        acc_fire = in_valid && in_ready;
        chk("in_ready", in_ready,
            ((sbq.size() - int'(ov)) == 0) || !ov || out_ready);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_R", R, prev_R);
        end
        if (ov) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_out: got R=%0d expected no output", R);
            end else begin
                e = sbq[0];
                if (!prev_stall && !prev_clr && e.clip) m_sat = 1;
                if (out_ready) begin
                    void'(sbq.pop_front());
                    chk("R", R, e.r);
                    rout = e.r;
                end
            end
        end
        chk("sat", sat, m_sat);
        if (acc_fire) begin
            raw = raw_sum();
            e.r = int'(clampw(raw, 16));
            e.clip = (longint'(e.r) != raw);
            sbq.push_back(e);
        end
        m_done = 0;
        if (ov && out_ready && !clr) begin
            lim = (ep_len == 0) ? 1 : int'(ep_len);
            v = ((m_cnt == 0) ? 0 : m_acc) + rout;
            m_acc = clampw(v, 24);
            if (m_acc != v) m_sat = 1;
            if (m_cnt == lim - 1) begin
                m_done = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (clr) begin
            m_acc = 0;
            m_cnt = 0;
            m_sat = 0;
        end
        prev_stall = ov && !out_ready;
        prev_R = R;
        prev_clr = clr;
        @(posedge clk);
        @(negedge clk);
        chk("R_acc", R_acc, m_acc);
        chk("ep_done", ep_done, m_done);
    endtask

    vec_t tbl[6];

    initial begin
        int  n8, t;
        bit  tog, hold;
        tbl[0] = '{tl: 4'd0, th: 4'd15, lv: 16'h0000, r: 40};
        tbl[1] = '{tl: 4'd0, th: 4'd15, lv: 16'hFFFF, r: -40};
        tbl[2] = '{tl: 4'd0, th: 4'd15, lv: 16'h55F0, r: -2};
        tbl[3] = '{tl: 4'd4, th: 4'd10, lv: 16'hC7B3, r: -11};
        tbl[4] = '{tl: 4'd8, th: 4'd5,  lv: 16'h9386, r: 20};
        tbl[5] = '{tl: 4'd0, th: 4'd15, lv: 16'h4321, r: -4};

        rst = 0;
        in_valid = 0; out_ready = 1; clr = 0; L_flat = '0;
        th_low = 4'd0; th_high = 4'd15; ep_len = 8'd4;
        r_low = 16'(R_LOW_DEF); r_mid = 16'(R_MID_DEF);
        r_high = 16'(R_HIGH_DEF);
        in_valid8 = 0; out_ready8 = 1; clr8 = 0; L8 = '0;
        r8_low = 8'sd100; r8_mid = -8'sd1; r8_high = -8'sd10;
        ep_len8 = 8'd20;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_R", R, 0);
        chk("rst_R_acc", R_acc, 0);
        chk("rst_ep_done", ep_done, 0);
        chk("rst_sat", sat, 0);
        repeat (2) @(negedge clk);
        rst = 1;

        // vector table: latency and classification
        foreach (tbl[k]) begin
            th_low = tbl[k].tl;
            th_high = tbl[k].th;
            L_flat = tbl[k].lv;
            in_valid = 1;
            step();
            in_valid = 0;
            chk("tbl_lat1_valid", out_valid, 0);
            step();
            chk("tbl_lat2_valid", out_valid, 1);
            chk("tbl_R", R, tbl[k].r);
            step();
        end
        th_low = 4'd0;
        th_high = 4'd15;

        // sustained throughput
        for (int k = 0; k < 4; k++) begin
            L_flat = 16'($urandom);
            in_valid = 1;
            step();
            chk("thru_accept", acc_fire, 1);
        end
        in_valid = 0;
        repeat (3) step();

        // back-to-back with alternating out_ready
        t = 0;
        tog = 1;
        L_flat = 16'($urandom);
        for (int k = 0; k < 100 && t < 8; k++) begin
            in_valid = 1;
            out_ready = tog;
            tog = !tog;
            step();
            if (acc_fire) begin
                t++;
                L_flat = 16'($urandom);
            end
        end
        chk("b2b_sent", t, 8);
        in_valid = 0;
        for (int k = 0; k < 40 && (sbq.size() != 0 || out_valid); k++) begin
            out_ready = tog;
            tog = !tog;
            step();
        end
        chk("b2b_drain", sbq.size(), 0);
        out_ready = 1;

        // episode of length 3
        clr = 1;
        ep_len = 8'd3;
        step();
        clr = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4);
            case (k)
                0: L_flat = 16'h0000;
                1: L_flat = 16'h55F0;
                2: L_flat = 16'hFFFF;
                3: begin L_flat = 16'hF550; r_mid = 16'sd5; end
                default: r_mid = 16'(R_MID_DEF);
            endcase
            step();
            if (k == 3) chk("ep_no_done", ep_done, 0);
            if (k == 4) begin
                chk("ep_done_3rd", ep_done, 1);
                chk("ep_total", R_acc, -2);
            end
            if (k == 5) chk("ep_fresh", R_acc, 10);
        end

        // clr coincident with an output transfer
        clr = 1;
        ep_len = 8'd2;
        step();
        clr = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 2) || (k == 4) || (k == 5);
            L_flat = (k < 2) ? 16'h0000 : (k == 4) ? 16'h55F0 : 16'hFFFF;
            clr = (k == 3);
            step();
            if (k == 2) begin
                chk("clr_pre_acc", R_acc, 40);
                chk("clr_R_ready", R, 40);
            end
            if (k == 3) begin
                chk("clr_acc", R_acc, 0);
                chk("clr_no_done", ep_done, 0);
            end
            if (k == 6) chk("clr_cnt_fresh", R_acc, -2);
            if (k == 7) begin
                chk("clr_ep_done", ep_done, 1);
                chk("clr_ep_total", R_acc, -42);
            end
        end
        clr = 0;

        // narrow instance saturation
        n8 = 0;
        chk("sat8_init", sat8, 0);
        for (int k = 0; k < 7; k++) begin
            in_valid8 = (k < 3);
            #1;
            if (out_valid8 && out_ready8) begin
                n8++;
                chk("sat8_R", R8, 127);
            end
            @(posedge clk);
            @(negedge clk);
            if (n8 == 1 && k == 2) chk("sat8_acc1", R_acc8, 127);
        end
        chk("sat8_count", n8, 3);
        chk("sat8_acc", R_acc8, 127);
        chk("sat8_flag", sat8, 1);

        // reset with both stages full
        in_valid = 1;
        out_ready = 0;
        L_flat = 16'h0000;
        repeat (3) step();
        chk("full_in_ready", in_ready, 0);
        #2;
        rst = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_R_acc", R_acc, 0);
        chk("mid_rst_R", R, 0);
        model_reset();
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        rst = 1;
        L_flat = 16'hFFFF;
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        chk("post_rst_R", R, -40);
        step();
        chk("post_rst_acc", R_acc, -40);

        // randomized traffic
        clr = 1;
        ep_len = 8'd3;
        step();
        hold = 0;
        for (int k = 0; k < 300; k++) begin
            if (!hold) begin
                in_valid = ($urandom % 4) != 0;
                L_flat = 16'($urandom);
            end
            if ($urandom % 12 == 0) begin
                th_low = 4'($urandom);
                th_high = 4'($urandom);
            end
            if ($urandom % 15 == 0) begin
                t = int'($urandom_range(24000)) - 12000;
                r_low = t[15:0];
                t = int'($urandom_range(24000)) - 12000;
                r_high = t[15:0];
                t = int'($urandom_range(200)) - 100;
                r_mid = t[15:0];
            end
            out_ready = ($urandom % 3) != 0;
            clr = ($urandom % 25) == 0;
            if (clr) ep_len = 8'($urandom % 5);
            step();
            hold = in_valid && !acc_fire;
        end
        clr = 0;
        in_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 10 && sbq.size() != 0; k++) step();
        chk("rand_drain", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rd_acc.md
RD_ACC -- requirements
Module: rd_acc

Interface
REQ-001 Parameter N_LANES, default 4: number of traffic lanes evaluated per step.
REQ-002 Parameter L_WIDTH, default 4: width of each lane queue level.
REQ-003 Parameter R_WIDTH, default 16: width of signed per-step reward R.
REQ-004 Parameter A_WIDTH, default 24: width of signed episode accumulator R_acc.
REQ-005 Parameter E_WIDTH, default 8: width of episode length and step counter.
REQ-006 Port clk, input, 1: single clock; all state on rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-low.
REQ-008 Port in_valid, input, 1: L_flat valid this cycle.
REQ-009 Port in_ready, output, 1: block accepts L_flat this cycle.
REQ-010 Port L_flat, input, N_LANES*L_WIDTH: lane levels, lane i at bits [i*L_WIDTH +: L_WIDTH].
REQ-011 Port th_low / th_high, input, L_WIDTH each: unsigned level thresholds.
REQ-012 Port r_low / r_mid / r_high, input, R_WIDTH each, signed: per-lane reward values (typ. +10 / -1 / -10).
REQ-013 Port ep_len, input, E_WIDTH: steps per episode.
REQ-014 Port clr, input, 1: synchronous clear of accumulator and step counter.
REQ-015 Port out_valid, output, 1: R valid.
REQ-016 Port out_ready, input, 1: consumer accepts R.
REQ-017 Port R, output, R_WIDTH, signed: summed step reward.
REQ-018 Port R_acc, output, A_WIDTH, signed: running episode reward including the last transferred R.
REQ-019 Port ep_done, output, 1: one-cycle pulse on the transfer completing an episode.
REQ-020 Port sat, output, 1: sticky; set when any R or R_acc saturation occurred since last clr/reset.

Function
REQ-021 Lane classification: L <= th_low -> r_low; else L >= th_high -> r_high; else r_mid; th_low check has priority when th_low >= th_high.
REQ-022 Stage 1 registers the N_LANES lane rewards; stage 2 registers their signed sum clamped to [-2^(R_WIDTH-1), 2^(R_WIDTH-1)-1], sat set on clamp.
REQ-023 Latency: accepted input appears on R with out_valid exactly 2 cycles later when out_ready held high.
REQ-024 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output); each stage advances only when its successor is empty or transferring.
REQ-025 in_ready = !stage1_valid || stage1 advancing; sustained throughput one step per cycle with out_ready high; no input is dropped or duplicated under any out_ready pattern.
REQ-026 R and out_valid hold stable while out_valid && !out_ready.
REQ-027 On each output transfer, R_acc <= saturate(R_acc + sign-extended R) to A_WIDTH, sat set on clamp; step counter increments.
REQ-028 On the transfer where step counter == max(ep_len,1)-1: ep_done pulses next cycle with R_acc holding the episode total; counter returns to 0; next transfer loads R_acc <= R (fresh episode).
REQ-029 ep_len = 0 treated as 1 (every transfer ends an episode).
REQ-030 clr simultaneous with output transfer: clr wins; R_acc, counter, sat clear to 0; R still delivered; no ep_done.
REQ-031 clr does not affect pipeline contents, in_ready or out_valid.
REQ-032 Threshold/reward/ep_len inputs are sampled at the stage using them; changes mid-stream affect only subsequently processed steps.

Reset
REQ-033 rst low asynchronously clears stage valids, out_valid, R, R_acc, counter, ep_done, sat to 0; in_ready is 1 during and after reset.
REQ-034 Reset asserted mid-transfer discards all in-flight steps; first output after release derives only from inputs accepted after release.

Structure
REQ-035 Shared package rd_pkg holds default reward constants (+10, -1, -10) and the signed saturation function used for R and R_acc.
REQ-036 Sub-module rd_lane (combinational classifier, one lane) is instantiated N_LANES times via generate.

Verification
REQ-037 Defaults, th_low=0, th_high=15, levels {0,0,0,0} -> R=+40 two cycles later; {15,15,15,15} -> R=-40; {0,15,5,5} -> R=-2.
REQ-038 Back-to-back 8 inputs, out_ready toggling 1010... -> all 8 R values out in order, none lost/duplicated, R stable while stalled.
REQ-039 ep_len=3, rewards +40,-2,-40,+10 -> ep_done pulse after 3rd transfer with R_acc=-2; after 4th R_acc=+10.
REQ-040 R_WIDTH=8, r_low=100, 4 lanes at level 0 -> R=127, sat=1; A_WIDTH=8 with repeated +127 -> R_acc clamps at 127.
REQ-041 clr coincident with output transfer R=+40 -> R_acc=0, counter=0, no ep_done, R=+40 still delivered.
REQ-042 rst pulsed low with both stages full -> out_valid=0 immediately, next output only from post-reset input, R_acc=0.
